// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter (double dabble) for the 4-digit display
// Produces packed BCD, a leading-zero blank mask and a saturation flag above 9999.
module bin2bcd_seq #(
    parameter int BW   = 14,
    parameter bit AUTO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BW-1:0] bin,
    input  logic          start,
    output logic          busy,
    output logic          valid,
    output logic [15:0]   bcd,
    output logic [3:0]    lz,
    output logic          ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam int         CW      = $clog2(BW + 1);

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] shreg_q, shreg_d;
    logic [BW-1:0] bin_q,   bin_d;
    logic [BW-1:0] last_q,  last_d;
    logic [19:0]   scr_q,   scr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          busy_q,  busy_d;
    logic          valid_q, valid_d;
    logic [15:0]   bcd_q,   bcd_d;
    logic [3:0]    lz_q,    lz_d;
    logic          ovf_q,   ovf_d;

    logic [19:0]   adj;
    logic [15:0]   res;

    // Five scratch digits so the full 14-bit range converts exactly before saturation.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < 5; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bin_d   = bin_q;
        last_d  = last_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        bcd_d   = bcd_q;
        lz_d    = lz_q;
        ovf_d   = ovf_q;
        res     = scr_q[15:0];
        case (state_q)
            S_IDLE: begin
                if (start || (AUTO && (bin != last_q))) begin
                    bin_d   = bin;
                    shreg_d = bin;
                    scr_d   = '0;
                    cnt_d   = CW'(BW);
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scr_d, shreg_d} = {adj, shreg_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (scr_q[19:16] != 4'd0) begin
                    res   = 16'h9999;
                    ovf_d = 1'b1;
                end else begin
                    res   = scr_q[15:0];
                    ovf_d = 1'b0;
                end
                bcd_d    = res;
                lz_d[3]  = (res[15:12] == 4'd0);
                lz_d[2]  = lz_d[3] && (res[11:8] == 4'd0);
                lz_d[1]  = lz_d[2] && (res[7:4] == 4'd0);
                lz_d[0]  = 1'b0;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                last_d   = bin_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bin_q   <= '0;
            last_q  <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= 16'h0000;
            lz_q    <= 4'b1110;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bin_q   <= bin_d;
            last_q  <= last_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            lz_q    <= lz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = bcd_q;
    assign lz    = lz_q;
    assign ovf   = ovf_q;

endmodule
